// File: rtl/mac_pkg.sv
// Shared widths, types and helpers for the complex multiply-accumulate unit.
// Components are signed Q2.6 bytes packed as {Re, Im}.
package mac_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned COMP_W      = 8;
    localparam int unsigned FRAC_BITS   = 6;
    localparam int unsigned ROUND_CONST = 32;
    localparam int unsigned INT_W       = 12;
    localparam int unsigned PROD_W      = 18;

    typedef logic [DATA_W-1:0]        word_t;
    typedef logic signed [COMP_W-1:0] comp_t;
    typedef logic signed [INT_W-1:0]  mid_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    typedef struct packed {
        comp_t re;
        comp_t im;
    } cplx_t;

    typedef struct packed {
        mid_t re;
        mid_t im;
    } cmid_t;

    typedef struct packed {
        logic  ovf;
        comp_t val;
    } sat_t;

    localparam comp_t SAT_MAX = 8'sh7F;
    localparam comp_t SAT_MIN = 8'sh80;
    localparam mid_t  MID_MAX = 12'sd127;
    localparam mid_t  MID_MIN = -12'sd128;

    function automatic mid_t sext(comp_t c);
        return {{(INT_W - COMP_W){c[COMP_W-1]}}, c};
    endfunction

    function automatic sat_t saturate(mid_t x);
        sat_t r;
        if (x > MID_MAX) begin
            r = '{ovf: 1'b1, val: SAT_MAX};
        end else if (x < MID_MIN) begin
            r = '{ovf: 1'b1, val: SAT_MIN};
        end else begin
            r = '{ovf: 1'b0, val: comp_t'(x)};
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_if.sv
// Sample and result bus of the MAC unit; the master drives samples, the slave returns results.
interface mac_if;
    import mac_pkg::*;

    word_t In1;
    word_t In2;
    word_t In3;
    word_t AddOut;
    word_t SubOut;
    logic  Overflow;

    modport master (output In1, In2, In3, input AddOut, SubOut, Overflow);
    modport slave  (input In1, In2, In3, output AddOut, SubOut, Overflow);

endinterface

// File: rtl/mac_cmul.sv
// Pipeline stage 1: complex product B*W, rounded half-up and rescaled back to Q.6,
// registered as 12-bit signed components.
module mac_cmul
    import mac_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  word_t b_i,
    input  word_t w_i,
    output cmid_t p_o
);

    cplx_t b, w;
    logic signed [15:0] rr, ii, ri, ir;
    prod_t sum_re, sum_im, rnd_re, rnd_im;
    cmid_t p_d, p_q;

    // 18-bit sums so that (-2.0)*(-2.0) + (-2.0)*(-2.0) = 32768 cannot wrap.
    always_comb begin
        b      = b_i;
        w      = w_i;
        rr     = b.re * w.re;
        ii     = b.im * w.im;
        ri     = b.re * w.im;
        ir     = b.im * w.re;
        sum_re = prod_t'(rr) - prod_t'(ii);
        sum_im = prod_t'(ri) + prod_t'(ir);
        rnd_re = sum_re + prod_t'(ROUND_CONST);
        rnd_im = sum_im + prod_t'(ROUND_CONST);
        p_d.re = mid_t'(rnd_re >>> FRAC_BITS);
        p_d.im = mid_t'(rnd_im >>> FRAC_BITS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mac_unit.sv
// Two-stage complex MAC: AddOut = A + B*W, SubOut = A - B*W, each component saturated to 8 bits.
// Stage 1 (mac_cmul plus delayed A) feeds the add/sub/saturate stage registered here.
module mac_unit
    import mac_pkg::*;
(
    input logic  clock,
    input logic  reset,
    mac_if.slave bus
);

    cmid_t p_q;
    cplx_t a_d, a_q;
    word_t add_d, add_q, sub_d, sub_q;
    logic  ovf_d, ovf_q;
    sat_t  s_add_re, s_add_im, s_sub_re, s_sub_im;

    mac_cmul u_cmul (
        .clock (clock),
        .reset (reset),
        .b_i   (bus.In2),
        .w_i   (bus.In3),
        .p_o   (p_q)
    );

    always_comb begin
        a_d      = bus.In1;
        s_add_re = saturate(sext(a_q.re) + p_q.re);
        s_add_im = saturate(sext(a_q.im) + p_q.im);
        s_sub_re = saturate(sext(a_q.re) - p_q.re);
        s_sub_im = saturate(sext(a_q.im) - p_q.im);
        add_d    = {s_add_re.val, s_add_im.val};
        sub_d    = {s_sub_re.val, s_sub_im.val};
        ovf_d    = s_add_re.ovf | s_add_im.ovf | s_sub_re.ovf | s_sub_im.ovf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '0;
            add_q <= '0;
            sub_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            add_q <= add_d;
            sub_q <= sub_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.AddOut   = add_q;
    assign bus.SubOut   = sub_q;
    assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: reset, latency, single vectors, overflow corner,
// back-to-back streaming and a reset in the middle of a stream.
module tb_mac_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mac_if bus ();

    mac_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Vectors 0..3: multiply by one, twiddle -j, positive saturation, negative saturation.
    logic [15:0] v_in1 [4] = '{16'h1020, 16'h0000, 16'h7F7F, 16'h8080};
    logic [15:0] v_in2 [4] = '{16'h2010, 16'h2010, 16'h4040, 16'h4040};
    logic [15:0] v_in3 [4] = '{16'h4000, 16'h00C0, 16'h4000, 16'h4000};
    logic [15:0] e_add [4] = '{16'h3030, 16'h10E0, 16'h7F7F, 16'hC0C0};
    logic [15:0] e_sub [4] = '{16'hF010, 16'hF020, 16'h3F3F, 16'h8080};
    logic        e_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
        bus.In1 = a;
        bus.In2 = b;
        bus.In3 = w;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(16'h7F7F, 16'h8080, 16'h8080);
        tick();
        tick();
        checks += 3;
        if (bus.AddOut !== 16'h0000) begin
            failures++;
            $display("FAIL reset_add got=%h want=0000", bus.AddOut);
        end
        if (bus.SubOut !== 16'h0000) begin
            failures++;
            $display("FAIL reset_sub got=%h want=0000", bus.SubOut);
        end
        if (bus.Overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b want=0", bus.Overflow);
        end
        // Stage 1 must also have been cleared, not loaded with the inputs held during reset.
        reset = 1'b0;
        drive(16'h0000, 16'h0000, 16'h0000);
        tick();
        checks++;
        if (bus.AddOut !== 16'h0000 || bus.SubOut !== 16'h0000 || bus.Overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_stage1 got=%h/%h/%b want=0000/0000/0",
                     bus.AddOut, bus.SubOut, bus.Overflow);
        end
        tick();
    endtask

    task automatic test_latency();
        drive(v_in1[0], v_in2[0], v_in3[0]);
        tick();
        checks++;
        if (bus.AddOut !== 16'h0000) begin
            failures++;
            $display("FAIL latency_early got=%h want=0000", bus.AddOut);
        end
        drive(16'h0000, 16'h0000, 16'h0000);
        tick();
        checks++;
        if (bus.AddOut !== e_add[0]) begin
            failures++;
            $display("FAIL latency_due got=%h want=%h", bus.AddOut, e_add[0]);
        end
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 4; i++) begin
            drive(v_in1[i], v_in2[i], v_in3[i]);
            tick();
            tick();
            checks += 3;
            if (bus.AddOut !== e_add[i]) begin
                failures++;
                $display("FAIL vec%0d_add got=%h want=%h", i, bus.AddOut, e_add[i]);
            end
            if (bus.SubOut !== e_sub[i]) begin
                failures++;
                $display("FAIL vec%0d_sub got=%h want=%h", i, bus.SubOut, e_sub[i]);
            end
            if (bus.Overflow !== e_ovf[i]) begin
                failures++;
                $display("FAIL vec%0d_ovf got=%b want=%b", i, bus.Overflow, e_ovf[i]);
            end
        end
    endtask

    // All components -2.0: P = 0 + j*512 must not wrap; im saturates both ways.
    task automatic test_boundary();
        drive(16'h0000, 16'h8080, 16'h8080);
        tick();
        tick();
        checks += 3;
        if (bus.AddOut !== 16'h007F) begin
            failures++;
            $display("FAIL boundary_add got=%h want=007F", bus.AddOut);
        end
        if (bus.SubOut !== 16'h0080) begin
            failures++;
            $display("FAIL boundary_sub got=%h want=0080", bus.SubOut);
        end
        if (bus.Overflow !== 1'b1) begin
            failures++;
            $display("FAIL boundary_ovf got=%b want=1", bus.Overflow);
        end
        // Overflow is not sticky.
        drive(v_in1[0], v_in2[0], v_in3[0]);
        tick();
        tick();
        checks++;
        if (bus.Overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b want=0", bus.Overflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(v_in1[i], v_in2[i], v_in3[i]);
            else drive(16'h0000, 16'h0000, 16'h0000);
            tick();
            if (i >= 1) begin
                checks += 3;
                if (bus.AddOut !== e_add[i-1] || bus.SubOut !== e_sub[i-1]
                    || bus.Overflow !== e_ovf[i-1]) begin
                    failures += 3;
                    $display("FAIL stream%0d got=%h/%h/%b want=%h/%h/%b", i - 1, bus.AddOut,
                             bus.SubOut, bus.Overflow, e_add[i-1], e_sub[i-1], e_ovf[i-1]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(v_in1[0], v_in2[0], v_in3[0]);
        tick();
        drive(v_in1[1], v_in2[1], v_in3[1]);
        tick();
        checks++;
        if (bus.AddOut !== e_add[0] || bus.SubOut !== e_sub[0]) begin
            failures++;
            $display("FAIL midrst_pre got=%h/%h want=%h/%h", bus.AddOut, bus.SubOut,
                     e_add[0], e_sub[0]);
        end
        reset = 1'b1;
        drive(v_in1[2], v_in2[2], v_in3[2]);
        tick();
        checks++;
        if (bus.AddOut !== 16'h0000 || bus.SubOut !== 16'h0000 || bus.Overflow !== 1'b0) begin
            failures++;
            $display("FAIL midrst_zero got=%h/%h/%b want=0000/0000/0",
                     bus.AddOut, bus.SubOut, bus.Overflow);
        end
        reset = 1'b0;
        drive(v_in1[3], v_in2[3], v_in3[3]);
        tick();
        checks++;
        if (bus.AddOut !== 16'h0000 || bus.SubOut !== 16'h0000 || bus.Overflow !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flush got=%h/%h/%b want=0000/0000/0",
                     bus.AddOut, bus.SubOut, bus.Overflow);
        end
        drive(v_in1[0], v_in2[0], v_in3[0]);
        tick();
        checks++;
        if (bus.AddOut !== e_add[3] || bus.SubOut !== e_sub[3] || bus.Overflow !== e_ovf[3]) begin
            failures++;
            $display("FAIL midrst_resume3 got=%h/%h/%b want=%h/%h/%b", bus.AddOut, bus.SubOut,
                     bus.Overflow, e_add[3], e_sub[3], e_ovf[3]);
        end
        drive(16'h0000, 16'h0000, 16'h0000);
        tick();
        checks++;
        if (bus.AddOut !== e_add[0] || bus.SubOut !== e_sub[0] || bus.Overflow !== e_ovf[0]) begin
            failures++;
            $display("FAIL midrst_resume0 got=%h/%h/%b want=%h/%h/%b", bus.AddOut, bus.SubOut,
                     bus.Overflow, e_add[0], e_sub[0], e_ovf[0]);
        end
    endtask

    initial begin
        drive(16'h0000, 16'h0000, 16'h0000);
        test_reset();
        test_latency();
        test_vectors();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
